video_timing_gen: RTL
=====================

// Module: video_timing_gen
// PURPOSE
//  Multi-mode CEA-861 raster timing generator for the HDMI output path.
//  Produces pixel counters, DE, HSYNC/VSYNC, frame strobe and down-scaled (tile) coordinates.
//  Supports 480p (VIC 2) and 720p (VIC 4) from one timing table, with runtime mode switch
//    applied only at frame boundary. Feeds TMDS encoder, framebuffer reader, InfoFrame packer.
// PARAMETERS
//  NUM_MODES     2    entries in timing table (0 = 480p, 1 = 720p)
//  DEFAULT_MODE  1    mode loaded at reset
//  X_W           11   pixel counter width (must hold max TOTALWIDTH-1 = 1649)
//  Y_W           10   line counter width (must hold max TOTALHEIGHT-1 = 749)
//  S_W           9    scaled-coordinate width
// PORTS
//  clk_pixel     in   1     pixel clock of the active mode
//  reset_n       in   1     synchronous, active-low reset
//  mode_sel      in   1     requested mode index; sampled every cycle
//  cx            out  X_W   horizontal position of the current pixel
//  cy            out  Y_W   vertical position of the current pixel
//  de            out  1     cx < SCREENWIDTH && cy < SCREENHEIGHT
//  hsync         out  1     horizontal sync, polarity per mode
//  vsync         out  1     vertical sync, polarity per mode
//  frame_start   out  1     one-cycle pulse while (cx,cy) = (0,0)
//  mode_active   out  1     mode index currently generated (drives PLL select/InfoFrame)
//  video_id      out  7     VIC of mode_active
//  mode_changed  out  1     one-cycle pulse with the first frame_start of a new mode
//  sx, sy        out  S_W   tile coords = cx/SCALE, cy/SCALE in active area; 0 outside
// BEHAVIOUR
//  Timing table (W, FP, SYNC, BP, TOTAL | pol; SCALE; VIC):
//    480p: H 720,16,62,60,858  V 480,9,6,30,525  sync active-low;  SCALE 3; VIC 2
//    720p: H 1280,110,40,220,1650  V 720,5,5,20,750  sync active-high; SCALE 5; VIC 4
//  - Internal counters hc,vc advance each cycle; hc wraps TOTALW-1->0 and increments vc;
//    vc wraps TOTALH-1->0. All outputs are registered from hc/vc: 1-cycle latency, mutually aligned.
//  - hsync active for W+FP <= cx < W+FP+SYNC; vsync active for H+FP <= cy < H+FP+SYNC.
//  - Reset: hc=vc=0, mode_active=DEFAULT_MODE, pending=DEFAULT_MODE; outputs cx=cy=0, de=0,
//    hsync/vsync at inactive level of DEFAULT_MODE, frame_start=0, mode_changed=0, sx=sy=0.
//    First cycle after release: outputs show (0,0), de=1, frame_start=1, mode_changed=0.
//  - Mode switch: pending <= mode_sel each cycle if mode_sel < NUM_MODES, else unchanged.
//    mode_active <= pending only on the wrap (hc,vc)=(TOTALW-1,TOTALH-1)->(0,0);
//    mode_changed=1 with that frame_start iff new != old. Last request before wrap wins;
//    request-and-revert within a frame produces no change. Never switch mid-frame.
//  - Tiles: phase counters px (0..SCALE-1), py (0..SCALE-1). Within active line sx increments
//    when px wraps; px,sx clear at hc wrap. sy increments when py wraps at each line end;
//    py,sy clear at vc wrap. On mode change all phases clear with the counters.
//  - Synchronous reset mid-frame aborts the frame; no partial mode change survives reset.
// STRUCTURE
//  - Shared config package: typedef struct video_timing_t {w,fp,sync,bp,total per axis,
//    sync_pol, scale, vic}; localparam video_timing_t VIDEO_MODES[NUM_MODES]; mode index enum.
//  - Sub-module scaled_coord_counter (instantiated twice: x and y): phase counter + tile
//    counter with advance, clear and scale inputs. No dividers anywhere.
// TESTING
//  1 reset_n=0 4 cycles, mode_sel=1 -> cx=cy=0, de=0, hsync=vsync=0; release -> frame_start=1 next cycle.
//  2 720p full frame -> de high 1280 cycles/line on 720 lines; hsync=1 exactly cx 1390..1429;
//    vsync=1 exactly cy 725..729; frame period 1,237,500 cycles.
//  3 480p -> hsync=0 exactly cx 736..797, vsync=0 exactly cy 489..494; period 858*525 cycles.
//  4 mode_sel 1->0 at cy=300 -> 720p continues to (1649,749); next cycle cx=cy=0,
//    mode_active=0, video_id=2, mode_changed=1; toggle 0->1->0 mid-frame -> no mode_changed.
//  5 720p tiles -> sx=0 for cx 0..4, sx=1 at cx 5, sx=255 at cx 1275..1279, sx=0 at cx 1280;
//    sy=143 on cy 715..719. 480p: sx=239 at cx 717..719.
//  6 reset_n pulsed at (cx,cy)=(900,400) with switch pending -> reset values, DEFAULT_MODE kept.
//  Bench checks all outputs against a cycle-accurate reference model every cycle.

Source files
------------

// File: rtl/video_timing_gen_pkg.sv
// Shared raster timing table, mode enum and field widths for the
// HDMI video timing generator.
package video_timing_gen_pkg;

    localparam int unsigned VTG_NUM_MODES = 2;
    localparam int unsigned VTG_X_W       = 11;
    localparam int unsigned VTG_Y_W       = 10;
    localparam int unsigned VTG_S_W       = 9;
    localparam int unsigned VTG_SCALE_W   = 3;
    localparam int unsigned VTG_VIC_W     = 7;

    typedef enum logic [0:0] {
        MODE_480P = 1'b0,
        MODE_720P = 1'b1
    } mode_e;

    // sync_pol = 1 means sync pulses are active-high
    typedef struct packed {
        logic [VTG_X_W-1:0]     h_w;
        logic [VTG_X_W-1:0]     h_fp;
        logic [VTG_X_W-1:0]     h_sync;
        logic [VTG_X_W-1:0]     h_bp;
        logic [VTG_X_W-1:0]     h_total;
        logic [VTG_Y_W-1:0]     v_w;
        logic [VTG_Y_W-1:0]     v_fp;
        logic [VTG_Y_W-1:0]     v_sync;
        logic [VTG_Y_W-1:0]     v_bp;
        logic [VTG_Y_W-1:0]     v_total;
        logic                   sync_pol;
        logic [VTG_SCALE_W-1:0] scale;
        logic [VTG_VIC_W-1:0]   vic;
    } video_timing_t;

    localparam video_timing_t VIDEO_MODES [VTG_NUM_MODES] = '{
        '{h_w: 11'd720,  h_fp: 11'd16,  h_sync: 11'd62, h_bp: 11'd60,  h_total: 11'd858,
          v_w: 10'd480,  v_fp: 10'd9,   v_sync: 10'd6,  v_bp: 10'd30,  v_total: 10'd525,
          sync_pol: 1'b0, scale: 3'd3, vic: 7'd2},
        '{h_w: 11'd1280, h_fp: 11'd110, h_sync: 11'd40, h_bp: 11'd220, h_total: 11'd1650,
          v_w: 10'd720,  v_fp: 10'd5,   v_sync: 10'd5,  v_bp: 10'd20,  v_total: 10'd750,
          sync_pol: 1'b1, scale: 3'd5, vic: 7'd4}
    };

endpackage

// File: rtl/video_timing_gen_scaled_coord_counter.sv
// Divider-free tile coordinate: a phase counter modulo scale that bumps the
// tile index on each phase wrap.
module video_timing_gen_scaled_coord_counter
    import video_timing_gen_pkg::*;
#(
    parameter int unsigned S_W = VTG_S_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   advance,
    input  logic [VTG_SCALE_W-1:0] scale,
    output logic [S_W-1:0]         tile
);

    logic [VTG_SCALE_W-1:0] phase_q, phase_d;
    logic [S_W-1:0]         tile_q, tile_d;

    always_comb begin
        phase_d = phase_q;
        tile_d  = tile_q;
        if (clear) begin
            phase_d = '0;
            tile_d  = '0;
        end else if (advance) begin
            if (phase_q == scale - VTG_SCALE_W'(1)) begin
                phase_d = '0;
                tile_d  = tile_q + S_W'(1);
            end else begin
                phase_d = phase_q + VTG_SCALE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q <= '0;
            tile_q  <= '0;
        end else begin
            phase_q <= phase_d;
            tile_q  <= tile_d;
        end
    end

    assign tile = tile_q;

endmodule

// File: rtl/video_timing_gen.sv
// Multi-mode CEA-861 raster generator: pixel/line counters, DE, syncs, frame
// strobe and tile coordinates, with mode switches taken only at frame wrap.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int unsigned NUM_MODES    = VTG_NUM_MODES,
    parameter int unsigned DEFAULT_MODE = 1,
    parameter int unsigned X_W          = VTG_X_W,
    parameter int unsigned Y_W          = VTG_Y_W,
    parameter int unsigned S_W          = VTG_S_W
) (
    input  logic                 clk_pixel,
    input  logic                 reset_n,
    input  logic                 mode_sel,
    output logic [X_W-1:0]       cx,
    output logic [Y_W-1:0]       cy,
    output logic                 de,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 frame_start,
    output logic                 mode_active,
    output logic [VTG_VIC_W-1:0] video_id,
    output logic                 mode_changed,
    output logic [S_W-1:0]       sx,
    output logic [S_W-1:0]       sy
);

    localparam mode_e RESET_MODE = mode_e'(1'(DEFAULT_MODE));
    localparam logic  RESET_SYNC = ~VIDEO_MODES[RESET_MODE].sync_pol;

    logic [X_W-1:0] hc_q, hc_d, h_last, h_ss, h_se;
    logic [Y_W-1:0] vc_q, vc_d, v_last, v_ss, v_se;
    mode_e          mode_q, mode_d, pend_q, pend_d;
    logic           chg_q, chg_d;
    logic           line_end, frame_end, h_act, v_act, h_in, v_in, pol;
    logic [VTG_SCALE_W-1:0] scale_c;
    logic [S_W-1:0] tile_x, tile_y;

    logic [X_W-1:0]       cx_q, cx_d;
    logic [Y_W-1:0]       cy_q, cy_d;
    logic                 de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic                 frame_start_q, frame_start_d, mode_changed_q, mode_changed_d;
    logic                 mode_active_q, mode_active_d;
    logic [VTG_VIC_W-1:0] video_id_q, video_id_d;
    logic [S_W-1:0]       sx_q, sx_d, sy_q, sy_d;

    // Counter advance, mode latch at frame wrap, and output decode of hc/vc
    always_comb begin
        h_last    = VIDEO_MODES[mode_q].h_total - X_W'(1);
        v_last    = VIDEO_MODES[mode_q].v_total - Y_W'(1);
        h_ss      = VIDEO_MODES[mode_q].h_w + VIDEO_MODES[mode_q].h_fp;
        h_se      = h_ss + VIDEO_MODES[mode_q].h_sync;
        v_ss      = VIDEO_MODES[mode_q].v_w + VIDEO_MODES[mode_q].v_fp;
        v_se      = v_ss + VIDEO_MODES[mode_q].v_sync;
        pol       = VIDEO_MODES[mode_q].sync_pol;
        scale_c   = VIDEO_MODES[mode_q].scale;
        line_end  = (hc_q == h_last);
        frame_end = line_end && (vc_q == v_last);
        h_act     = (hc_q < VIDEO_MODES[mode_q].h_w);
        v_act     = (vc_q < VIDEO_MODES[mode_q].v_w);
        h_in      = (hc_q >= h_ss) && (hc_q < h_se);
        v_in      = (vc_q >= v_ss) && (vc_q < v_se);

        hc_d = line_end ? '0 : hc_q + X_W'(1);
        vc_d = vc_q;
        if (line_end) begin
            vc_d = frame_end ? '0 : vc_q + Y_W'(1);
        end

        pend_d = pend_q;
        if (32'(mode_sel) < NUM_MODES) begin
            pend_d = mode_e'(mode_sel);
        end
        mode_d = frame_end ? pend_q : mode_q;
        chg_d  = frame_end && (pend_q != mode_q);

        cx_d           = hc_q;
        cy_d           = vc_q;
        de_d           = h_act && v_act;
        hsync_d        = ~(h_in ^ pol);
        vsync_d        = ~(v_in ^ pol);
        frame_start_d  = (hc_q == '0) && (vc_q == '0);
        mode_active_d  = mode_q;
        video_id_d     = VIDEO_MODES[mode_q].vic;
        mode_changed_d = chg_q;
        sx_d           = de_d ? tile_x : '0;
        sy_d           = de_d ? tile_y : '0;
    end

    // x tile tracks hc within the active line; y tile steps once per active line
    video_timing_gen_scaled_coord_counter #(.S_W(S_W)) u_sx (
        .clk     (clk_pixel),
        .reset_n (reset_n),
        .clear   (line_end),
        .advance (h_act),
        .scale   (scale_c),
        .tile    (tile_x)
    );

    video_timing_gen_scaled_coord_counter #(.S_W(S_W)) u_sy (
        .clk     (clk_pixel),
        .reset_n (reset_n),
        .clear   (frame_end),
        .advance (line_end && v_act),
        .scale   (scale_c),
        .tile    (tile_y)
    );

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            hc_q           <= '0;
            vc_q           <= '0;
            mode_q         <= RESET_MODE;
            pend_q         <= RESET_MODE;
            chg_q          <= 1'b0;
            cx_q           <= '0;
            cy_q           <= '0;
            de_q           <= 1'b0;
            hsync_q        <= RESET_SYNC;
            vsync_q        <= RESET_SYNC;
            frame_start_q  <= 1'b0;
            mode_active_q  <= RESET_MODE;
            video_id_q     <= VIDEO_MODES[RESET_MODE].vic;
            mode_changed_q <= 1'b0;
            sx_q           <= '0;
            sy_q           <= '0;
        end else begin
            hc_q           <= hc_d;
            vc_q           <= vc_d;
            mode_q         <= mode_d;
            pend_q         <= pend_d;
            chg_q          <= chg_d;
            cx_q           <= cx_d;
            cy_q           <= cy_d;
            de_q           <= de_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            frame_start_q  <= frame_start_d;
            mode_active_q  <= mode_active_d;
            video_id_q     <= video_id_d;
            mode_changed_q <= mode_changed_d;
            sx_q           <= sx_d;
            sy_q           <= sy_d;
        end
    end

    assign cx           = cx_q;
    assign cy           = cy_q;
    assign de           = de_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign frame_start  = frame_start_q;
    assign mode_active  = mode_active_q;
    assign video_id     = video_id_q;
    assign mode_changed = mode_changed_q;
    assign sx           = sx_q;
    assign sy           = sy_q;

endmodule
